// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADDU = 5'b00000;
    localparam logic [4:0] OP_SUBU = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_NOR  = 5'b00111;
    localparam logic [4:0] OP_LUI0 = 5'b01000;
    localparam logic [4:0] OP_LUI1 = 5'b01001;
    localparam logic [4:0] OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_SLT  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_SRL  = 5'b01101;
    localparam logic [4:0] OP_SLL0 = 5'b01110;
    localparam logic [4:0] OP_SLL1 = 5'b01111;
    localparam logic [4:0] OP_MULU = 5'b10000;
    localparam logic [4:0] OP_DIVU = 5'b10001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Status flags in the order they are bundled on the result side.
    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
        logic div_zero;
        logic illegal;
    } flags_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] lo_c,
    output logic [WIDTH-1:0] hi_c
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // hi:lo is the product accumulator (multiplier in lo) or remainder:dividend.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        div_d  = div_q;
        m_d    = m_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_c = 1'b0;

        addend    = lo_q[0] ? m_q : '0;
        mul_sum   = {1'b0, hi_q} + {1'b0, addend};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_ge    = div_shift >= {1'b0, m_q};

        if (start) begin
            m_d    = is_div ? b : a;
            lo_d   = is_div ? a : b;
            hi_d   = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            div_d  = is_div;
        end else if (busy_q) begin
            if (div_q) begin
                hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_ge};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_c = 1'b1;
            end
        end
    end

    // The parent registers the post-step values on the final step edge.
    assign lo_c = lo_d;
    assign hi_c = hi_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            m_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            div_q  <= div_d;
            m_q    <= m_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle ops plus iterative MULU/DIVU.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned HALF = WIDTH / 2;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    flags_t           flags_q, flags_d;
    logic             div_q, div_d;
    logic             bz_q, bz_d;

    logic             accept;
    logic             md_start;
    logic             md_done;
    logic             op_div;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    logic [WIDTH-1:0] alu_r;
    flags_t           alu_f;
    logic             alu_zn;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             ltu;
    logic             ovf_add;
    logic             ovf_sub;
    logic [SHW-1:0]   sh;
    logic [SHW-1:0]   shm1;
    logic             sat;
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] srl_v;
    logic [WIDTH-1:0] sll_v;
    logic [WIDTH-1:0] rsrc;
    logic [WIDTH-1:0] lsrc;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign op_div   = (op == OP_DIVU);

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (op_div),
        .a      (a),
        .b      (b),
        .done_c (md_done),
        .lo_c   (md_lo),
        .hi_c   (md_hi)
    );

    // Single-cycle datapath; carry of a shift is the last bit shifted out.
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        ltu     = diff[WIDTH];
        ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        sh      = a[SHW-1:0];
        shm1    = sh - SHW'(1);
        sat     = a >= WIDTH'(WIDTH);
        sra_v   = WIDTH'($signed(b) >>> sh);
        srl_v   = b >> sh;
        sll_v   = b << sh;
        rsrc    = b >> shm1;
        lsrc    = b << shm1;

        alu_r  = '0;
        alu_f  = '0;
        alu_zn = 1'b1;

        case (op)
            OP_ADDU: begin
                alu_r       = sum[WIDTH-1:0];
                alu_f.carry = sum[WIDTH];
            end
            OP_ADD: begin
                alu_r          = sum[WIDTH-1:0];
                alu_f.overflow = ovf_add;
            end
            OP_SUBU: begin
                alu_r       = diff[WIDTH-1:0];
                alu_f.carry = ltu;
            end
            OP_SUB: begin
                alu_r          = diff[WIDTH-1:0];
                alu_f.overflow = ovf_sub;
            end
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_NOR: alu_r = ~(a | b);
            OP_LUI0, OP_LUI1: alu_r = {b[HALF-1:0], {HALF{1'b0}}};
            OP_SLT: begin
                alu_r          = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
                alu_f.overflow = ovf_sub;
            end
            OP_SLTU: begin
                alu_r       = {{(WIDTH-1){1'b0}}, ltu};
                alu_f.carry = ltu;
            end
            OP_SRA: begin
                if (sat) begin
                    alu_r       = {WIDTH{b[WIDTH-1]}};
                    alu_f.carry = b[WIDTH-1];
                end else begin
                    alu_r       = sra_v;
                    alu_f.carry = (sh != '0) && rsrc[0];
                end
            end
            OP_SRL: begin
                if (!sat) begin
                    alu_r       = srl_v;
                    alu_f.carry = (sh != '0) && rsrc[0];
                end
            end
            OP_SLL0, OP_SLL1: begin
                if (!sat) begin
                    alu_r       = sll_v;
                    alu_f.carry = (sh != '0) && lsrc[WIDTH-1];
                end
            end
            OP_MULU, OP_DIVU: alu_zn = 1'b0;
            default: begin
                alu_zn        = 1'b0;
                alu_f.illegal = 1'b1;
            end
        endcase

        if (alu_zn) begin
            alu_f.zero     = (alu_r == '0);
            alu_f.negative = alu_r[WIDTH-1];
        end
    end

    // Control: DONE with out_ready doubles as IDLE so results can stream.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        hi_d        = hi_q;
        flags_d     = flags_q;
        div_d       = div_q;
        bz_d        = bz_q;
        md_start    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if ((state_q == DONE) && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (is_muldiv(op)) begin
                        md_start    = 1'b1;
                        state_d     = BUSY;
                        out_valid_d = 1'b0;
                        div_d       = op_div;
                        bz_d        = (b == '0);
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        r_d         = alu_r;
                        hi_d        = '0;
                        flags_d     = alu_f;
                    end
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    r_d         = md_lo;
                    hi_d        = md_hi;
                    flags_d     = '0;
                    if (div_q) begin
                        flags_d.zero     = (md_lo == '0);
                        flags_d.div_zero = bz_q;
                    end else begin
                        flags_d.zero     = ({md_hi, md_lo} == '0);
                        flags_d.negative = md_hi[WIDTH-1];
                        flags_d.overflow = (md_hi != '0);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            hi_q        <= '0;
            flags_q     <= '0;
            div_q       <= 1'b0;
            bz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            hi_q        <= hi_d;
            flags_q     <= flags_d;
            div_q       <= div_d;
            bz_q        <= bz_d;
        end
    end

    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign hi        = hi_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign negative  = flags_q.negative;
    assign overflow  = flags_q.overflow;
    assign div_zero  = flags_q.div_zero;
    assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven scoreboard bench for alu_seq plus latency, stall and reset sequences.
module tb_alu_seq;

    localparam int unsigned W = 32;
    // flag vector order: {zero, carry, negative, overflow, div_zero, illegal}
    localparam logic [5:0] ALL    = 6'b111111;
    localparam logic [5:0] NO_NEG = 6'b110111;

    typedef struct {
        string        name;
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic [5:0]   fl;
        logic [5:0]   mask;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic [5:0]   fl;
        logic [5:0]   mask;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         zero, carry, negative, overflow, div_zero, illegal;
    logic [5:0]   fl_now;

    int   tests = 0;
    int   fails = 0;
    logic bp_en = 1'b0;
    exp_t sb[$];
    vec_t vt[$];

    assign fl_now = {zero, carry, negative, overflow, div_zero, illegal};

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .hi        (hi),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mkv(input string nm, input logic [4:0] o,
                                 input logic [W-1:0] x, y, er, eh,
                                 input logic [5:0] ef, em);
        vec_t v;
        v.name = nm; v.op = o; v.a = x; v.b = y;
        v.r = er; v.hi = eh; v.fl = ef; v.mask = em;
        return v;
    endfunction

    // Present one operation, wait for acceptance, then queue its expected result.
    task automatic send(input vec_t v, output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
        #1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
            #1;
            waited++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL %s_accept: in_ready stuck at 0 after %0d cycles", v.name, waited);
            in_valid = 1'b0;
        end else begin
            e.name = v.name; e.r = v.r; e.hi = v.hi; e.fl = v.fl; e.mask = v.mask;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            #3;
            n++;
        end
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    // Output monitor: scoreboard pop on transfer, stability check while stalled.
    logic         stall_prev = 1'b0;
    logic [127:0] snap;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_stable", 128'({out_valid, r, hi, fl_now}), snap);
            stall_prev = out_valid && !out_ready;
            snap       = 128'({out_valid, r, hi, fl_now});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: got r=%0h hi=%0h, expected no result", r, hi);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, 128'({r, hi, fl_now & e.mask}), 128'({e.r, e.hi, e.fl & e.mask}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int           waited;
        int           n;
        int           rdy_seen;
        logic [127:0] hold;

        vt.push_back(mkv("addu_wrap", 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 6'b110000, ALL));
        vt.push_back(mkv("add_ovf",   5'b00010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 6'b001100, ALL));
        vt.push_back(mkv("subu_neg",  5'b00001, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 6'b011000, ALL));
        vt.push_back(mkv("sub_ovf",   5'b00011, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 6'b000100, ALL));
        vt.push_back(mkv("and",       5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 6'b001000, ALL));
        vt.push_back(mkv("or",        5'b00101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 6'b000000, ALL));
        vt.push_back(mkv("xor_zero",  5'b00110, 32'hAAAA5555, 32'hAAAA5555, 32'h0, 0, 6'b100000, ALL));
        vt.push_back(mkv("nor",       5'b00111, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 6'b001000, ALL));
        vt.push_back(mkv("lui0",      5'b01000, 32'h0, 32'h1234ABCD, 32'hABCD0000, 0, 6'b001000, ALL));
        vt.push_back(mkv("lui1",      5'b01001, 32'h0, 32'h00005678, 32'h56780000, 0, 6'b000000, ALL));
        vt.push_back(mkv("sltu",      5'b01010, 32'd3, 32'd9, 32'h1, 0, 6'b010000, ALL));
        vt.push_back(mkv("slt_ovf",   5'b01011, 32'h80000000, 32'h1, 32'h1, 0, 6'b000100, ALL));
        vt.push_back(mkv("slt_false", 5'b01011, 32'd5, 32'd3, 32'h0, 0, 6'b100000, ALL));
        vt.push_back(mkv("sra4",      5'b01100, 32'd4, 32'h80000010, 32'hF8000001, 0, 6'b001000, ALL));
        vt.push_back(mkv("sra_sat",   5'b01100, 32'd32, 32'h80000000, 32'hFFFFFFFF, 0, 6'b011000, ALL));
        vt.push_back(mkv("srl1",      5'b01101, 32'd1, 32'h80000001, 32'h40000000, 0, 6'b010000, ALL));
        vt.push_back(mkv("srl0",      5'b01101, 32'd0, 32'h12345678, 32'h12345678, 0, 6'b000000, ALL));
        vt.push_back(mkv("srl_sat",   5'b01101, 32'd100, 32'hFFFFFFFF, 32'h0, 0, 6'b100000, ALL));
        vt.push_back(mkv("sll1",      5'b01110, 32'd1, 32'h80000001, 32'h2, 0, 6'b010000, ALL));
        vt.push_back(mkv("sll_alt",   5'b01111, 32'd2, 32'h40000000, 32'h0, 0, 6'b110000, ALL));
        vt.push_back(mkv("sll_sat",   5'b01110, 32'd40, 32'h1, 32'h0, 0, 6'b100000, ALL));
        vt.push_back(mkv("illegal",   5'b10110, 32'h5, 32'h6, 32'h0, 0, 6'b000001, ALL));
        vt.push_back(mkv("mulu_max",  5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 6'b001100, ALL));
        vt.push_back(mkv("mulu_2p32", 5'b10000, 32'h10000, 32'h10000, 32'h0, 32'h1, 6'b000100, ALL));
        vt.push_back(mkv("mulu_zero", 5'b10000, 32'h0, 32'd5, 32'h0, 32'h0, 6'b100000, ALL));
        vt.push_back(mkv("divu_100_7",5'b10001, 32'd100, 32'd7, 32'd14, 32'd2, 6'b000000, NO_NEG));
        vt.push_back(mkv("divu_big",  5'b10001, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 6'b000000, NO_NEG));
        vt.push_back(mkv("divu_small",5'b10001, 32'd7, 32'd9, 32'h0, 32'd7, 6'b100000, NO_NEG));

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
        chk("rst_r",         128'(r),         128'(0));
        chk("rst_hi",        128'(hi),        128'(0));
        chk("rst_flags",     128'(fl_now),    128'(0));
        #1 rst_n = 1'b1;

        // Single-cycle latency
        send(mkv("add_ovf_seq", 5'b00010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 6'b001100, ALL), waited);
        @(negedge clk); in_valid = 1'b0; #2;
        chk("add_latency", 128'(out_valid), 128'(1'b1));
        drain();

        // Back-to-back SUBU then SLTU
        send(mkv("b2b_subu", 5'b00001, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 6'b011000, ALL), waited);
        send(mkv("b2b_sltu", 5'b01010, 32'd3, 32'd9, 32'h1, 0, 6'b010000, ALL), waited);
        chk("b2b_no_wait", 128'(waited), 128'(0));
        @(negedge clk); in_valid = 1'b0; #2;
        chk("b2b_second_valid", 128'(out_valid), 128'(1'b1));
        drain();

        // Vector table, first with out_ready high, then with random backpressure
        for (int p = 0; p < 2; p++) begin
            bp_en = (p == 1);
            for (int i = 0; i < vt.size(); i++) send(vt[i], waited);
            drain();
        end
        bp_en = 1'b0;
        out_ready = 1'b1;

        // MULU latency and in_ready low while busy
        send(mkv("mulu_ff_2", 5'b10000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1, 6'b000100, ALL), waited);
        n = 0; rdy_seen = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk); in_valid = 1'b0; #2;
            n++;
            if (!out_valid && in_ready) rdy_seen++;
        end
        chk("mulu_latency", 128'(n), 128'(33));
        chk("mulu_busy_in_ready", 128'(rdy_seen), 128'(0));
        drain();

        // DIVU by zero held under backpressure
        out_ready = 1'b0;
        send(mkv("divu_by0", 5'b10001, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 6'b000010, NO_NEG), waited);
        n = 0;
        @(negedge clk); in_valid = 1'b0; #2;
        while (!out_valid && n < 40) begin
            @(negedge clk); #2; n++;
        end
        chk("divz_valid", 128'(out_valid), 128'(1'b1));
        chk("divz_div_zero", 128'(div_zero), 128'(1'b1));
        hold = 128'({r, hi, fl_now});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            chk("hold_outputs",  128'({r, hi, fl_now}), hold);
            chk("hold_in_ready", 128'(in_ready), 128'(1'b0));
            chk("hold_valid",    128'(out_valid), 128'(1'b1));
        end
        drain();

        // Reset in the middle of a MULU
        send(mkv("mulu_abandon", 5'b10000, 32'd5, 32'd6, 32'd30, 32'd0, 6'b000000, ALL), waited);
        @(negedge clk); in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_in_ready",  128'(in_ready),  128'(1'b1));
        chk("midrst_r",         128'(r),         128'(0));
        sb.delete();
        @(negedge clk); #3 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (out_valid) n++;
        end
        chk("midrst_no_result", 128'(n), 128'(0));

        send(mkv("illegal_10110", 5'b10110, 32'h1234, 32'h5678, 32'h0, 32'h0, 6'b000001, ALL), waited);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 4-bit-opcode ALU.
- Computes every legacy operation with a registered result: 1-cycle latency, full throughput.
- Adds iterative unsigned multiply and divide through an internal state machine.
- Sits between the CPU's operand-read stage and write-back.
- Results and flags are held stable until the consumer accepts them.

Parameters:
- WIDTH, 32: operand/result width; must be even and >= 8.
- SHW, $clog2(WIDTH): derived localparam, counter and shift-index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op present
- in_ready  out  1  block can accept this cycle
- op  in  5  opcode; op[4]=0 legacy aluc codes in op[3:0], op[4]=1 extended
- a  in  WIDTH  operand A (shift amount for shifts)
- b  in  WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  WIDTH  result / low product / quotient
- hi  out  WIDTH  high product / remainder; 0 for non-muldiv ops
- zero, carry, negative, overflow  out  1 each  status flags
- div_zero  out  1  DIVU with b==0
- illegal  out  1  undefined opcode

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; r, hi and all flags 0; iteration counter 0.
  - A reset mid-iteration abandons the operation; no result is ever presented.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Output transfer occurs when out_valid && out_ready.
  - r, hi and flags stay stable while out_valid && !out_ready.
- States:
  - IDLE: on accept of a single-cycle op -> DONE, result registered. On accept of MULU/DIVU -> BUSY, counter=0.
  - BUSY: one multiply/divide step per cycle; in_ready=0. After step WIDTH-1 -> DONE.
  - DONE: out_valid=1. If out_ready and a new accept -> behave as IDLE accept, giving back-to-back throughput. If out_ready and no accept -> IDLE.
- Latency: single-cycle ops have out_valid the cycle after accept. MULU/DIVU have out_valid WIDTH+1 cycles after accept.
- Legacy ops, all mod 2^WIDTH; zero = (r==0) and negative = r[WIDTH-1] unless stated:
  - 0000 ADDU: carry = carry-out.
  - 0010 ADD: overflow = (a,b same sign) && r sign differs.
  - 0001 SUBU: carry = (a<b) unsigned.
  - 0011 SUB: overflow = (signs differ) && r sign != a sign.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 100x LUI: r = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 1011 SLT: r = signed a<b (0/1); overflow computed as SUB.
  - 1010 SLTU: r = carry = unsigned a<b.
  - 1100 SRA, 1101 SRL, 111x SLL: shift b by a.
  - Shift amount a >= WIDTH saturates: SRA gives all copies of b[WIDTH-1]; SRL/SLL give 0.
  - Shift carry = last bit shifted out: b[a-1] for right shifts, b[WIDTH-a] for left.
  - Shift carry for a==0 is 0. Shift carry for a >= WIDTH: SRA b[WIDTH-1], SRL/SLL 0.
  - Flags not listed for an op are 0.
- Extended ops:
  - 10000 MULU: {hi,r} = a*b, shift-add over WIDTH cycles. overflow = (hi!=0); zero = ({hi,r}==0); negative = hi[WIDTH-1].
  - 10001 DIVU: restoring divide; r = quotient, hi = remainder. zero = (r==0).
  - DIVU with b==0: r = all ones, hi = a, div_zero=1; still takes the full WIDTH cycles.
- Undefined op (op[4]=1 and op[3:0] not 0000/0001):
  - Completes in 1 cycle with r=hi=0, illegal=1, other flags 0.
  - Replaces the previous high-impedance behaviour.
- Operands are latched at accept; input changes during BUSY have no effect.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADDU .. OP_DIVU)
  - state enum (IDLE, BUSY, DONE)
  - flag bundle ordering
- Sub-module alu_iter_muldiv: owns the counter, the partial-product/remainder registers and the step datapath; signals done to the parent FSM.
- Single-cycle ops remain combinational inside alu_seq, with registered output.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF + 1, out_ready=1 -> next cycle out_valid=1, r=0x80000000, overflow=1, negative=1, carry=0.
- Back-to-back SUBU 5-7 then SLTU 3,9 with out_ready held 1 -> consecutive-cycle results:
  - r=0xFFFFFFFE, carry=1
  - r=1
- SRA b=0x80000010, a=4 -> r=0xF8000001, carry=0. SLL b=1, a=40 -> r=0, carry=0.
- MULU 0xFFFFFFFF * 2 -> out_valid at cycle 33, r=0xFFFFFFFE, hi=1, overflow=1. in_ready=0 throughout BUSY.
- DIVU 100/7 -> r=14, hi=2. DIVU 9/0 -> r=0xFFFFFFFF, hi=9, div_zero=1. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
- Start MULU, drop rst_n at cycle 10 -> out_valid=0 immediately, state IDLE. Op 10110 -> illegal=1, r=0.
